// File: rtl/dst_pkg.sv
// Shared constants and types for the router destination-port output stage.
package dst_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TIMEOUT = 30;

  localparam int PTR_W = $clog2(DEF_DEPTH);

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [PTR_W:0]        cnt_t;
  typedef logic [DEF_DATA_W-1:0] byte_t;

endpackage

// File: rtl/dst_timeout_ctr.sv
// Unread-data watchdog for dst_modport; only compiled when DST_TIMEOUT_EN is defined.
`ifdef DST_TIMEOUT_EN
module dst_timeout_ctr
  import dst_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic valid_out,
  input  logic read_enb,
  output logic soft_reset,
  output logic flush
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt;

  // Combinational so the FIFO clears on the same edge that raises soft_reset.
  assign flush = valid_out && !read_enb && (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= flush;
      if (!valid_out || read_enb || flush)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/dst_modport.sv
// Destination-port output stage: byte FIFO with valid/read handshake and full backpressure.
// Optional unread-data flush is built when DST_TIMEOUT_EN is defined.
module dst_modport
  import dst_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write_enb,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              soft_reset
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  if ((DEPTH != (1 << PW)) || (DEPTH < 2) || (TIMEOUT < 2)) begin : g_bad_cfg
    $error("dst_modport: DEPTH must be a power of 2 and TIMEOUT at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              wr_acc;
  logic              rd_acc;
  logic              flush;

  assign valid_out = (count != '0);
  assign busy      = (count == FULL);
  assign wr_acc    = write_enb && !busy && !flush;
  assign rd_acc    = read_enb && valid_out && !flush;

`ifdef DST_TIMEOUT_EN
  dst_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock      (clock),
    .reset_n    (reset_n),
    .valid_out  (valid_out),
    .read_enb   (read_enb),
    .soft_reset (soft_reset),
    .flush      (flush)
  );
`else
  assign flush      = 1'b0;
  assign soft_reset = 1'b0;
`endif

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc)
        count <= count + 1'b1;
      else if (rd_acc && !wr_acc)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_dst_modport.sv
// Directed self-checking bench for dst_modport; the timeout section follows DST_TIMEOUT_EN.
module tb_dst_modport;
  import dst_pkg::*;

  logic  clock;
  logic  reset_n;
  logic  write_enb;
  byte_t data_in;
  logic  read_enb;
  byte_t data_out;
  logic  valid_out;
  logic  busy;
  logic  soft_reset;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen_soft;

  dst_modport dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .write_enb  (write_enb),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .soft_reset (soft_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input byte_t d);
    write_enb = 1'b1;
    data_in   = d;
    cyc();
    write_enb = 1'b0;
  endtask

  task automatic rd(input string tag, input byte_t exp);
    read_enb = 1'b1;
    cyc();
    read_enb = 1'b0;
    chk(tag, data_out, exp);
  endtask

  initial begin
    reset_n = 1'b0; write_enb = 1'b0; data_in = '0; read_enb = 1'b0;
    cyc(); cyc();
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_soft", soft_reset, 1'b0);
    reset_n = 1'b1;
    cyc();

    // single byte round trip
    wr(8'hA5);
    chk("single_valid", valid_out, 1'b1);
    rd("single_data", 8'hA5);
    chk("single_empty", valid_out, 1'b0);
    rd("empty_read_holds", 8'hA5);

    // fill, overflow drop, simultaneous access when full
    for (int i = 0; i < 16; i++) wr(byte_t'(i));
    chk("full_busy", busy, 1'b1);
    wr(8'hFF);
    chk("full_drop_busy", busy, 1'b1);
    write_enb = 1'b1; data_in = 8'h55; read_enb = 1'b1;
    cyc();
    write_enb = 1'b0; read_enb = 1'b0;
    chk("full_rw_data", data_out, 8'h00);
    chk("full_rw_busy", busy, 1'b0);
    for (int i = 1; i < 16; i++) rd($sformatf("order_%0d", i), byte_t'(i));
    chk("order_empty", valid_out, 1'b0);

    // simultaneous read/write at count=5 keeps count
    for (int i = 0; i < 5; i++) wr(byte_t'(8'h10 + i));
    write_enb = 1'b1; data_in = 8'h20; read_enb = 1'b1;
    cyc();
    write_enb = 1'b0; read_enb = 1'b0;
    chk("rw5_data", data_out, 8'h10);
    rd("rw5_r1", 8'h11);
    rd("rw5_r2", 8'h12);
    rd("rw5_r3", 8'h13);
    rd("rw5_r4", 8'h14);
    chk("rw5_still_valid", valid_out, 1'b1);
    rd("rw5_r5", 8'h20);
    chk("rw5_empty", valid_out, 1'b0);

    // asynchronous reset mid-traffic
    wr(8'h31); wr(8'h32); wr(8'h33);
    rd("pre_rst_data", 8'h31);
    write_enb = 1'b1; data_in = 8'h44;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_data", data_out, 8'h00);
    chk("async_rst_valid", valid_out, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_soft", soft_reset, 1'b0);
    write_enb = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_valid", valid_out, 1'b0);

`ifdef DST_TIMEOUT_EN
    wr(8'h77);
    rd("to_pre_data", 8'h77);
    // E1 write; counted edges E2..E30 leave counter at 29
    wr(8'h41);
    seen_soft = 1'b0;
    for (int k = 2; k <= 30; k++) begin
      if (k <= 3) begin write_enb = 1'b1; data_in = byte_t'(8'h40 + k - 1); end
      cyc();
      write_enb = 1'b0;
      seen_soft = seen_soft | soft_reset;
    end
    chk("to_no_early_soft", seen_soft, 1'b0);
    chk("to_valid_before", valid_out, 1'b1);
    write_enb = 1'b1; data_in = 8'h99;
    cyc();
    write_enb = 1'b0;
    chk("to_soft_pulse", soft_reset, 1'b1);
    chk("to_flush_valid", valid_out, 1'b0);
    chk("to_flush_data", data_out, 8'h00);
    cyc();
    chk("to_soft_one_cycle", soft_reset, 1'b0);
    chk("to_flush_write_dropped", valid_out, 1'b0);

    // read on the 29th counted edge restarts the count
    wr(8'h61);
    seen_soft = 1'b0;
    for (int k = 2; k <= 29; k++) begin
      if (k <= 3) begin write_enb = 1'b1; data_in = byte_t'(8'h60 + k); end
      cyc();
      write_enb = 1'b0;
      seen_soft = seen_soft | soft_reset;
    end
    rd("to_var_read", 8'h61);
    for (int k = 0; k < 10; k++) begin
      cyc();
      seen_soft = seen_soft | soft_reset;
    end
    chk("to_var_no_soft", seen_soft, 1'b0);
    chk("to_var_valid", valid_out, 1'b1);
    rd("to_var_r2", 8'h62);
    rd("to_var_r3", 8'h63);
`else
    wr(8'h81); wr(8'h82);
    seen_soft = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      seen_soft = seen_soft | soft_reset;
    end
    chk("noto_soft", seen_soft, 1'b0);
    chk("noto_valid", valid_out, 1'b1);
    rd("noto_r1", 8'h81);
    rd("noto_r2", 8'h82);
    chk("noto_empty", valid_out, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
